reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the register; legal range 2..8.
REQ-002 Parameter W, default 8: width of the shared data register.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 n_Reset  input  1  asynchronous, active-low reset; takes precedence over CLK.
REQ-005 req  input  N  per-requester access request; level, held by the requester until it is finished.
REQ-006 din  input  N*W  packed write data; requester i occupies bits [i*W+W-1 : i*W].
REQ-007 grant  output  N  one-hot grant to the current owner; all zero when no owner.
REQ-008 ack  output  1  single-cycle pulse: the register has loaded the owner's data.
REQ-009 Q  output  W  shared register contents.
REQ-010 owner  output  clog2(N)  index of the most recently granted requester.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement three states: IDLE, GRANT and HOLD.
REQ-013 In IDLE with req != 0, the block SHALL, at the next edge, select the winner, set grant to the winner's one-hot, set owner to the winner index, and enter GRANT.
REQ-014 Round-robin arbitration SHALL search from the index held in pointer ptr upward, wrapping from N-1 to 0; the first set req bit wins.
REQ-015 In GRANT with req[owner]=1, the block SHALL, at the next edge, load Q with din slice [owner], drive ack=1 for exactly that one cycle, and enter HOLD.
REQ-016 In GRANT with req[owner]=0 (abort), the block SHALL leave Q unchanged, keep ack at 0, clear grant, set ptr to (owner+1) mod N, and return to IDLE.
REQ-017 In HOLD, grant SHALL remain asserted and Q SHALL hold its value; changes on din are ignored.
REQ-018 In HOLD, when req[owner] is sampled as 0, the block SHALL clear grant, set ptr to (owner+1) mod N, and return to IDLE at that edge.
REQ-019 Changes on req bits other than owner SHALL have no effect while the state is GRANT or HOLD.
REQ-020 A requester that keeps req high after release SHALL NOT be re-granted before the other pending requesters, because of the round-robin pointer.
REQ-021 Minimum latency SHALL be:
  - req rise in IDLE to grant: 1 cycle;
  - grant to ack: 1 cycle;
  - req[owner] fall to grant fall: 1 cycle.
REQ-022 The minimum spacing between successive grants SHALL be 3 cycles, with no idle bubble beyond the IDLE state.
REQ-023 grant, ack, Q and owner SHALL be registered outputs; busy SHALL be decoded from the state register only.
REQ-024 The module SHALL instantiate no latches; all storage SHALL be edge-triggered flip-flops.

Reset
REQ-025 While n_Reset=0, regardless of CLK, the block SHALL force: state=IDLE, grant=0, ack=0, Q=0, owner=0, ptr=0, busy=0.
REQ-026 Reset asserted in GRANT or HOLD SHALL abort the transaction immediately, with no ack and no load of Q.
REQ-027 On the first rising CLK edge after n_Reset rises, the block SHALL evaluate req normally from IDLE with ptr=0.

Verification
REQ-028 Reset then single requester (N=4, W=8): req=0001, din[7:0]=8'hA5 -> grant=0001 after 1 edge, then ack pulse and Q=8'hA5 after 2 edges; req=0 -> grant=0 after 1 edge.
REQ-029 Simultaneous requests: req=1111 held, each owner releasing one cycle after its ack -> grant order 0001, 0010, 0100, 1000, 0001; exactly one ack per grant.
REQ-030 Wrap-around: ptr=3 after serving requester 2, req=1001 -> grant=1000 first, then 0001.
REQ-031 Abort: requester 1 drops req during GRANT -> no ack, Q unchanged, grant=0 next cycle, next winner searched from index 2.
REQ-032 Async reset mid-HOLD: n_Reset pulsed low between clock edges -> grant, ack, Q, owner and busy read 0 within the same cycle; after release, req=0100 -> grant=0100.
REQ-033 Din hold: change din for the owner while in HOLD -> Q unchanged until the next ack.

Source files
------------

// File: rtl/reg_arbiter.sv
// Round-robin arbiter guarding a shared W-bit register among N requesters.
// A winner is granted, its data is loaded once (ack), and it holds ownership until it drops req.
module reg_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 CLK,
  input  logic                 n_Reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         grant,
  output logic                 ack,
  output logic [W-1:0]         Q,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int unsigned OW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   w_grant_nxt;
  logic           r_ack;
  logic           w_ack_nxt;
  logic [W-1:0]   r_q;
  logic [W-1:0]   w_q_nxt;
  logic [OW-1:0]  r_owner;
  logic [OW-1:0]  w_owner_nxt;
  logic [OW-1:0]  r_ptr;
  logic [OW-1:0]  w_ptr_nxt;

  logic           w_found;
  logic [OW-1:0]  w_winner;
  logic [N-1:0]   w_winner_onehot;
  logic [OW-1:0]  w_owner_inc;
  logic [W-1:0]   w_owner_din;

  // First set req bit at or above r_ptr, wrapping past N-1 back to 0.
  always_comb begin
    logic [OW-1:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = OW'((32'(r_ptr) + k) % N);
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  assign w_winner_onehot = N'(1) << w_winner;
  assign w_owner_inc     = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);
  assign w_owner_din     = din[r_owner*W +: W];

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ack_nxt   = 1'b0;
    w_q_nxt     = r_q;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_winner_onehot;
          w_owner_nxt = w_winner;
        end
      end
      GRANT: begin
        if (req[r_owner]) begin
          w_state_nxt = HOLD;
          w_q_nxt     = w_owner_din;
          w_ack_nxt   = 1'b1;
        end else begin
          // Owner withdrew before the load: release without touching Q.
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
        end
      end
      HOLD: begin
        if (!req[r_owner]) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_grant <= '0;
      r_ack   <= 1'b0;
      r_q     <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_q     <= w_q_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign grant = r_grant;
  assign ack   = r_ack;
  assign Q     = r_q;
  assign owner = r_owner;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench for reg_arbiter (N=4, W=8): expected grants and loaded data are queued
// as stimulus is driven and checked by a monitor as grants rise and acks pulse.
module tb_reg_arbiter;

  logic        CLK;
  logic        n_Reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  grant;
  logic        ack;
  logic [7:0]  Q;
  logic [1:0]  owner;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ack  = 0;

  logic [3:0] exp_grant[$];
  logic [7:0] exp_q[$];
  logic [3:0] prev_grant;
  logic       prev_ack;
  logic [3:0] mon_g;
  logic [7:0] mon_q;

  reg_arbiter #(.N(4), .W(8)) dut (
    .CLK     (CLK),
    .n_Reset (n_Reset),
    .req     (req),
    .din     (din),
    .grant   (grant),
    .ack     (ack),
    .Q       (Q),
    .owner   (owner),
    .busy    (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_ack(input string tag);
    int c;
    c = 0;
    do begin
      tick(1);
      c++;
    end while (!ack && c < 10);
    if (!ack) chk(tag, 32'(ack), 32'd1);
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    din[i*8 +: 8] = v;
  endtask

  function automatic logic [7:0] slice(input int i);
    return din[i*8 +: 8];
  endfunction

  task automatic expect_txn(input int i, input bit with_load);
    exp_grant.push_back(4'(1 << i));
    if (with_load) exp_q.push_back(slice(i));
  endtask

  // Monitor: each new grant and each ack is matched against the scoreboard.
  always @(negedge CLK) begin
    if (!n_Reset) begin
      prev_grant = '0;
      prev_ack   = 1'b0;
    end else begin
      if (grant != 4'd0 && prev_grant == 4'd0) begin
        if (exp_grant.size() == 0) begin
          chk("grant_unexpected", 32'(grant), 32'd0);
        end else begin
          mon_g = exp_grant.pop_front();
          chk("grant_order", 32'(grant), 32'(mon_g));
        end
      end
      if (ack) begin
        n_ack++;
        chk("ack_width", 32'(prev_ack), 32'd0);
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          mon_q = exp_q.pop_front();
          chk("ack_q", 32'(Q), 32'(mon_q));
        end
      end
      prev_grant = grant;
      prev_ack   = ack;
    end
  end

  initial begin
    int base;
    n_Reset = 1'b0;
    req     = '0;
    din     = '0;
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_q",     32'(Q),     32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    n_Reset = 1'b1;
    tick(1);

    // Single requester: grant after 1 edge, ack + load after 2, release after 1.
    set_din(0, 8'hA5);
    expect_txn(0, 1'b1);
    req = 4'b0001;
    tick(1);
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_busy",  32'(busy),  32'd1);
    chk("single_noack", 32'(ack),   32'd0);
    tick(1);
    chk("single_ack", 32'(ack), 32'd1);
    chk("single_q",   32'(Q),   32'hA5);
    req = 4'b0000;
    tick(1);
    chk("single_release", 32'(grant), 32'd0);
    chk("single_ack_low", 32'(ack),   32'd0);

    // Re-reset so the pointer restarts at 0.
    n_Reset = 1'b0;
    #2;
    n_Reset = 1'b1;
    tick(1);

    // All four requesting: strict rotation 0,1,2,3,0 with one ack each.
    set_din(0, 8'h11);
    set_din(1, 8'h22);
    set_din(2, 8'h33);
    set_din(3, 8'h44);
    for (int k = 0; k < 5; k++) expect_txn(k % 4, 1'b1);
    base = n_ack;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("rr_ack_timeout");
      chk("rr_owner", 32'(owner), 32'(k % 4));
      if (k == 4) req = 4'b0000;
      else        req[k % 4] = 1'b0;
      tick(1);
      chk("rr_release", 32'(grant), 32'd0);
      if (k < 4) req[k % 4] = 1'b1;
    end
    chk("rr_ack_count", 32'(n_ack - base), 32'd5);

    // Serve requester 2 so the pointer sits at 3, then 3 must beat 0.
    expect_txn(2, 1'b1);
    req = 4'b0100;
    wait_ack("wrap_ack2_timeout");
    req = 4'b0000;
    tick(1);
    expect_txn(3, 1'b1);
    expect_txn(0, 1'b1);
    req = 4'b1001;
    wait_ack("wrap_ack3_timeout");
    chk("wrap_first", 32'(grant), 32'h8);
    req[3] = 1'b0;
    tick(1);
    wait_ack("wrap_ack0_timeout");
    chk("wrap_second", 32'(grant), 32'h1);
    req = 4'b0000;
    tick(1);
    chk("wrap_owner", 32'(owner), 32'd0);

    // Abort: requester 1 drops during GRANT; next search must start at 2.
    set_din(1, 8'hEE);
    expect_txn(1, 1'b0);
    req = 4'b0010;
    tick(1);
    chk("abort_grant_on", 32'(grant), 32'h2);
    req = 4'b0000;
    tick(1);
    chk("abort_grant_off", 32'(grant), 32'd0);
    chk("abort_noack",     32'(ack),   32'd0);
    chk("abort_q_kept",    32'(Q),     32'h11);
    chk("abort_busy",      32'(busy),  32'd0);
    set_din(0, 8'h3C);
    expect_txn(0, 1'b1);
    req = 4'b0011;
    wait_ack("abort_next_timeout");
    chk("abort_next_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick(1);

    // Din changes during HOLD must not reach Q until the next ack.
    set_din(1, 8'h77);
    expect_txn(1, 1'b1);
    req = 4'b0010;
    wait_ack("hold_ack_timeout");
    set_din(1, 8'h99);
    tick(2);
    chk("hold_q",     32'(Q),     32'h77);
    chk("hold_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick(1);
    expect_txn(1, 1'b1);
    req = 4'b0010;
    wait_ack("hold_ack2_timeout");
    chk("hold_q_reload", 32'(Q), 32'h99);
    req = 4'b0000;
    tick(1);

    // Asynchronous reset mid-HOLD, between clock edges.
    expect_txn(0, 1'b1);
    req = 4'b0001;
    wait_ack("arst_ack_timeout");
    tick(1);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    n_Reset = 1'b0;
    req     = 4'b0000;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ack",   32'(ack),   32'd0);
    chk("arst_q",     32'(Q),     32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    #1;
    n_Reset = 1'b1;
    expect_txn(2, 1'b1);
    req = 4'b0100;
    tick(1);
    chk("arst_regrant", 32'(grant), 32'h4);
    chk("arst_owner2",  32'(owner), 32'd2);
    wait_ack("arst_ack2_timeout");
    req = 4'b0000;
    tick(1);
    chk("final_grant", 32'(grant), 32'd0);
    chk("final_busy",  32'(busy),  32'd0);
    tick(2);

    chk("sb_grant_left", 32'(exp_grant.size()), 32'd0);
    chk("sb_q_left",     32'(exp_q.size()),     32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
